// File: rtl/sequence_generator_if.sv
// Handshake/bus bundle for the serial pattern transmitter.
// The control side drives ena/start/num_zeros. The generator drives the serial bit, status and displays.
interface sequence_generator_if #(
    parameter int ZW = 4
);
    logic          ena;
    logic          start;
    logic [ZW-1:0] num_zeros;
    logic          sig_out;
    logic          busy;
    logic          frame_done;
    logic [6:0]    disp0;
    logic [6:0]    disp1;

    modport master (
        output ena, start, num_zeros,
        input  sig_out, busy, frame_done, disp0, disp1
    );

    modport slave (
        input  ena, start, num_zeros,
        output sig_out, busy, frame_done, disp0, disp1
    );
endinterface

// File: rtl/sequence_generator.sv
// Emits 0,1,[0 x N],1 frames one bit per enabled clock.
// Counts completed frames modulo 100 and shows the count on two active-low 7-segment digits.
//
// state   | meaning
// --------+-------------------------------------------------
// IDLE    | line parked at 1, waiting for start
// SEND_0  | leading 0 of the frame
// SEND_1A | first 1 of the frame
// SEND_Z  | middle zeros, zero counter counts down
// SEND_1B | closing 1; start here chains the next frame
module sequence_generator #(
    parameter int ZW = 4
) (
    input  logic          clk,
    input  logic          rst,
    sequence_generator_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEND_0  = 3'd1,
        SEND_1A = 3'd2,
        SEND_Z  = 3'd3,
        SEND_1B = 3'd4
    } state_t;

    state_t        state, state_nxt;
    logic [ZW-1:0] zcnt, zcnt_nxt;
    logic          enter_1b;
    logic          sig_out_q, sig_out_nxt;
    logic          busy_q, busy_nxt;
    logic          frame_done_q;
    logic [3:0]    ones_q, tens_q;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0011000;
            default: s = 7'b0000111;
        endcase
        return s;
    endfunction

    always_comb begin
        state_nxt = state;
        zcnt_nxt  = zcnt;
        enter_1b  = 1'b0;
        if (bus.ena) begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state_nxt = SEND_0;
                        zcnt_nxt  = bus.num_zeros;
                    end
                end
                SEND_0: state_nxt = SEND_1A;
                SEND_1A: begin
                    if (zcnt == '0) begin
                        state_nxt = SEND_1B;
                        enter_1b  = 1'b1;
                    end else begin
                        state_nxt = SEND_Z;
                    end
                end
                SEND_Z: begin
                    // Leaving when the counter reads 1 keeps exactly N cycles in this state.
                    if (zcnt <= ZW'(1)) begin
                        state_nxt = SEND_1B;
                        enter_1b  = 1'b1;
                    end
                    zcnt_nxt = (zcnt == '0) ? '0 : zcnt - ZW'(1);
                end
                SEND_1B: begin
                    if (bus.start) begin
                        state_nxt = SEND_0;
                        zcnt_nxt  = bus.num_zeros;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        sig_out_nxt = 1'b1;
        if (state_nxt == SEND_0 || state_nxt == SEND_Z)
            sig_out_nxt = 1'b0;
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            zcnt         <= '0;
            sig_out_q    <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            ones_q       <= 4'd0;
            tens_q       <= 4'd0;
        end else begin
            state        <= state_nxt;
            zcnt         <= zcnt_nxt;
            sig_out_q    <= sig_out_nxt;
            busy_q       <= busy_nxt;
            // enter_1b is only ever set on enabled edges, so this clears on any edge.
            frame_done_q <= enter_1b;
            if (enter_1b) begin
                if (ones_q == 4'd9) begin
                    ones_q <= 4'd0;
                    tens_q <= (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
                end else begin
                    ones_q <= ones_q + 4'd1;
                end
            end
        end
    end

    assign bus.sig_out    = sig_out_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
    assign bus.disp0      = seg7(ones_q);
    assign bus.disp1      = seg7(tens_q);
endmodule

// File: tb/tb_sequence_generator.sv
// Randomized and directed bench for sequence_generator.
// It uses a frame-level bit-queue reference model.
module tb_sequence_generator;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sequence_generator_if #(.ZW(4)) bus ();
    sequence_generator #(.ZW(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_vec  = 0;
    int n_fail = 0;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000};

    // Reference model: bits still to send in the current frame, plus the visible outputs.
    int   q[$];
    bit   m_in_frame;
    bit   m_bit;
    bit   m_fd;
    int   m_count;
    int   frames;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_in_frame = 1'b0;
        m_bit      = 1'b1;
        m_fd       = 1'b0;
        m_count    = 0;
    endtask

    task automatic model_edge();
        m_fd = 1'b0;
        if (!bus.ena) return;
        if (m_in_frame && q.size() > 0) begin
            m_bit = q.pop_front()[0];
            if (q.size() == 0) begin
                m_fd    = 1'b1;
                m_count = (m_count + 1) % 100;
                frames++;
            end
        end else if (bus.start) begin
            q.delete();
            q.push_back(0);
            q.push_back(1);
            for (int i = 0; i < int'(bus.num_zeros); i++) q.push_back(0);
            q.push_back(1);
            m_bit      = q.pop_front()[0];
            m_in_frame = 1'b1;
        end else begin
            m_in_frame = 1'b0;
            m_bit      = 1'b1;
        end
    endtask

    task automatic compare_all();
        check_val("sig_out",    32'(bus.sig_out),    32'(m_bit));
        check_val("busy",       32'(bus.busy),       32'(m_in_frame));
        check_val("frame_done", 32'(bus.frame_done), 32'(m_fd));
        check_val("disp0",      32'(bus.disp0),      32'(seg_tab[m_count % 10]));
        check_val("disp1",      32'(bus.disp1),      32'(seg_tab[m_count / 10]));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    // Asynchronous reset asserted mid-clock; outputs must be at reset values before the next edge.
    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_val("rst_sig_out",    32'(bus.sig_out),    32'd1);
        check_val("rst_busy",       32'(bus.busy),       32'd0);
        check_val("rst_frame_done", 32'(bus.frame_done), 32'd0);
        check_val("rst_disp0",      32'(bus.disp0),      32'h40);
        check_val("rst_disp1",      32'(bus.disp1),      32'h40);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic exp_bits [6];
        logic exp_fd   [6];
        int   f0;

        bus.ena       = 1'b1;
        bus.start     = 1'b0;
        bus.num_zeros = 4'd0;
        model_reset();
        frames = 0;
        do_reset();

        // Single N=2 frame, start pulsed for one cycle.
        exp_bits = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        exp_fd   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        bus.start = 1'b1; bus.num_zeros = 4'd2;
        for (int i = 0; i < 6; i++) begin
            cycle();
            bus.start = 1'b0;
            check_val("n2_bit", 32'(bus.sig_out),    32'(exp_bits[i]));
            check_val("n2_fd",  32'(bus.frame_done), 32'(exp_fd[i]));
            check_val("n2_busy", 32'(bus.busy), (i < 5) ? 32'd1 : 32'd0);
        end
        check_val("n2_disp0", 32'(bus.disp0), 32'h79);
        check_val("n2_disp1", 32'(bus.disp1), 32'h40);

        // N=0 frame.
        bus.start = 1'b1; bus.num_zeros = 4'd0;
        cycle(); bus.start = 1'b0;
        cycle(); cycle(); cycle();
        check_val("n0_disp0", 32'(bus.disp0), 32'h24);

        // Back-to-back with N=1, then num_zeros changed mid-frame.
        bus.start = 1'b1; bus.num_zeros = 4'd1;
        for (int i = 0; i < 10; i++) cycle();
        bus.num_zeros = 4'd3;
        for (int i = 0; i < 14; i++) cycle();
        bus.start = 1'b0;
        for (int i = 0; i < 8; i++) cycle();

        // ena dropped for 3 cycles inside SEND_Z, and again as frame_done rises.
        bus.start = 1'b1; bus.num_zeros = 4'd2;
        cycle(); bus.start = 1'b0;
        cycle(); cycle();
        bus.ena = 1'b0;
        cycle(); cycle(); cycle();
        check_val("ena_hold_bit", 32'(bus.sig_out), 32'd0);
        bus.ena = 1'b1;
        for (int i = 0; i < 2; i++) cycle();
        check_val("ena_fd_rise", 32'(bus.frame_done), 32'd1);
        bus.ena = 1'b0;
        cycle();
        check_val("ena_fd_width", 32'(bus.frame_done), 32'd0);
        bus.ena = 1'b1;
        cycle(); cycle();

        // Wrap: continuous N=0 frames from a clean count.
        do_reset();
        frames = 0;
        bus.start = 1'b1; bus.num_zeros = 4'd0;
        for (int i = 0; i < 320 && frames < 100; i++) begin
            f0 = frames;
            cycle();
            if (frames == 10 && f0 == 9) begin
                check_val("wrap10_disp1", 32'(bus.disp1), 32'h79);
                check_val("wrap10_disp0", 32'(bus.disp0), 32'h40);
            end
        end
        check_val("wrap100_frames", 32'(frames), 32'd100);
        check_val("wrap100_disp0", 32'(bus.disp0), 32'h40);
        check_val("wrap100_disp1", 32'(bus.disp1), 32'h40);

        // Abort mid-frame: count must stay at zero afterwards.
        bus.num_zeros = 4'd5;
        cycle(); cycle(); cycle();
        bus.start = 1'b0;
        do_reset();
        for (int i = 0; i < 10; i++) cycle();
        check_val("abort_disp0", 32'(bus.disp0), 32'h40);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            bus.ena       = ($urandom % 4) != 0;
            bus.start     = ($urandom % 3) == 0;
            bus.num_zeros = ($urandom % 4 == 0) ? 4'($urandom % 16) : 4'($urandom % 4);
            if ($urandom % 300 == 0) do_reset();
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
